seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 36 +++
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the sequential restoring divider.
//   div_state_t : FSM state encoding (IDLE, CALC, DONE)
//   DIV_WIDTH   : default operand/result width
//   DIV_CNT_W   : iteration counter width for the default width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// div_step
// One restoring-division iteration: shift the partial remainder left,
// bring in the next dividend bit, trial-subtract the divisor and keep
// the difference only when it did not go negative.
// Ports:
//   p_in         : partial remainder entering the iteration (WIDTH bits)
//   dividend_bit : next dividend bit, MSB first
//   divisor      : divisor magnitude
//   p_out        : partial remainder leaving the iteration
//   q_bit        : quotient bit produced by this iteration
module div_step
#(
    parameter int WIDTH = 4
)
(
    input  logic [WIDTH-1:0] p_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor, so it fits in
    // WIDTH bits; the shift needs one extra bit so the trial subtraction
    // can expose a borrow in its MSB.
    always_comb begin
        shifted = {p_in, dividend_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        p_out   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle restoring divider. A start pulse while not busy latches the
// operands; WIDTH iterations later a one-cycle done pulse presents the
// quotient and remainder, which are held until the next accepted start.
// Dividing by zero skips the iterations and reports on the next cycle.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : request, accepted only when busy is low
//   dividend     : numerator, sampled on accept
//   divisor      : denominator, sampled on accept
//   busy         : high while iterating
//   done         : one-cycle pulse, results valid
//   quotient     : result, held until the next accept
//   remainder    : result, held until the next accept
//   div_by_zero  : divisor was zero, held with the results
// Build option:
//   DIV_SIGNED_EN : treat operands as two's complement (truncating
//                   division, remainder follows dividend sign)
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             last_iter;
    logic             divisor_zero;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] step_p;
    logic             step_q;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;

`ifdef DIV_SIGNED_EN
    assign dividend_neg = dividend[WIDTH-1];
    assign divisor_neg  = divisor[WIDTH-1];
`else
    assign dividend_neg = 1'b0;
    assign divisor_neg  = 1'b0;
`endif

    // The core only ever sees magnitudes; the most-negative value maps to
    // itself, which is still its correct unsigned magnitude.
    assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
    assign divisor_zero = (divisor == '0);

    assign accept    = start && (state != CALC);
    assign last_iter = (state == CALC) && (cnt == LAST_CNT);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in         (p_reg),
        .dividend_bit (dvd_reg[WIDTH-1]),
        .divisor      (dvs_reg),
        .p_out        (step_p),
        .q_bit        (step_q)
    );

    // The dividend register shifts out its MSB each iteration while the new
    // quotient bit enters at the LSB, so after the last iteration it holds
    // the full quotient; q_raw is that final value one cycle early.
    assign q_raw   = {dvd_reg[WIDTH-2:0], step_q};
    assign q_fixed = neg_q ? (~q_raw + 1'b1) : q_raw;
    assign r_fixed = neg_r ? (~step_p + 1'b1) : step_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status flags; a start in DONE is accepted directly so
    // divisions can run back to back.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture on accept, one iteration per CALC cycle,
    // sign-corrected results loaded on the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            p_reg       <= '0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            p_reg   <= '0;
            dvd_reg <= dividend_mag;
            dvs_reg <= divisor_mag;
            neg_q   <= dividend_neg ^ divisor_neg;
            neg_r   <= dividend_neg;
            if (divisor_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            p_reg   <= step_p;
            dvd_reg <= q_raw;
            if (last_iter) begin
                cnt       <= '0;
                quotient  <= q_fixed;
                remainder <= r_fixed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Directed checks of seq_divider at WIDTH=4: reset values, normal
// division timing and results, divide by zero, back-to-back operation,
// start ignored while busy, reset mid-division, and (with DIV_SIGNED_EN)
// signed vectors.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total;
    int bad;

`ifdef DIV_SIGNED_EN
    // 13 = -3 and 9 = -7 when read as signed 4-bit values
    localparam logic [W-1:0] Q13_3 = 4'b1111;
    localparam logic [W-1:0] R13_3 = 4'b0000;
    localparam logic [W-1:0] Q9_4  = 4'b1111;
    localparam logic [W-1:0] R9_4  = 4'b1101;
`else
    localparam logic [W-1:0] Q13_3 = 4'd4;
    localparam logic [W-1:0] R13_3 = 4'd1;
    localparam logic [W-1:0] Q9_4  = 4'd2;
    localparam logic [W-1:0] R9_4  = 4'd1;
`endif

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Moves to 1 time unit after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single clock; returns just after the
    // accepting edge.
    task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        nextCycle();
        start = 1'b0;
    endtask

    // Waits (bounded) for done, checking busy stayed high while waiting and
    // that done arrived the expected number of cycles later.
    task automatic waitDone(input string tag, input int expLat);
        int n;
        int busyBad;
        n       = 0;
        busyBad = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy !== 1'b1) busyBad++;
            nextCycle();
            n++;
        end
        checkOutput({tag, "_latency"}, n, expLat);
        checkOutput({tag, "_busy_gaps"}, busyBad, 0);
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        checkOutput({tag, "_done"}, done, 1'b1);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_q"}, quotient, q);
        checkOutput({tag, "_r"}, remainder, r);
        checkOutput({tag, "_dbz"}, div_by_zero, z);
    endtask

    initial begin
        int doneSeen;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        nextCycle();
        nextCycle();

        // reset values
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_q", quotient, 4'd0);
        checkOutput("rst_r", remainder, 4'd0);
        checkOutput("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        nextCycle();

        // 13 / 3: busy for four cycles, then done
        applyStimulus(4'd13, 4'd3);
        waitDone("d13_3", W);
        checkResult("d13_3", Q13_3, R13_3, 1'b0);
        nextCycle();
        checkOutput("d13_3_pulse_end", done, 1'b0);
        checkOutput("d13_3_hold_q", quotient, Q13_3);
        checkOutput("d13_3_hold_r", remainder, R13_3);

        // 7 / 0: immediate done, no busy
        applyStimulus(4'd7, 4'd0);
        waitDone("d7_0", 0);
        checkResult("d7_0", 4'd15, 4'd7, 1'b1);
        nextCycle();
        checkOutput("d7_0_pulse_end", done, 1'b0);

        // 2 / 9 then 15 / 1 started in the done cycle
        applyStimulus(4'd2, 4'd9);
        waitDone("d2_9", W);
        checkResult("d2_9", 4'd0, 4'd2, 1'b0);
        applyStimulus(4'd15, 4'd1);
        waitDone("d15_1", W);
`ifdef DIV_SIGNED_EN
        checkResult("d15_1", 4'b1111, 4'd0, 1'b0);
`else
        checkResult("d15_1", 4'd15, 4'd0, 1'b0);
`endif
        nextCycle();

        // 6 / 2 requested while 13 / 3 is iterating must be ignored
        applyStimulus(4'd13, 4'd3);
        nextCycle();
        applyStimulus(4'd6, 4'd2);
        waitDone("ignore", W - 2);
        checkResult("ignore", Q13_3, R13_3, 1'b0);
        nextCycle();

        // reset during an iteration clears everything, no done pulse
        applyStimulus(4'd13, 4'd3);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_q", quotient, 4'd0);
        checkOutput("midrst_r", remainder, 4'd0);
        checkOutput("midrst_dbz", div_by_zero, 1'b0);
        doneSeen = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (done === 1'b1) doneSeen++;
            nextCycle();
        end
        checkOutput("midrst_no_done", doneSeen, 0);
        applyStimulus(4'd9, 4'd4);
        waitDone("d9_4", W);
        checkResult("d9_4", Q9_4, R9_4, 1'b0);
        nextCycle();

`ifdef DIV_SIGNED_EN
        // -7 / 2 = -3 rem -1
        applyStimulus(4'b1001, 4'b0010);
        waitDone("sm7_2", W);
        checkResult("sm7_2", 4'b1101, 4'b1111, 1'b0);
        nextCycle();
        // -8 / -1 wraps to -8 rem 0, no flag
        applyStimulus(4'b1000, 4'b1111);
        waitDone("sm8_m1", W);
        checkResult("sm8_m1", 4'b1000, 4'b0000, 1'b0);
        nextCycle();
        // -6 / 0: all ones, remainder is the dividend
        applyStimulus(4'b1010, 4'b0000);
        waitDone("sm6_0", 0);
        checkResult("sm6_0", 4'b1111, 4'b1010, 1'b1);
        nextCycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
